sr_latch_sequencer: RTL and testbench

SR_LATCH_SEQUENCER -- requirements
Module: sr_latch_sequencer

---
 rtl/sr_latch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sr_latch_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_sequencer.sv
// -----------------------------------------------------------------------------
// sr_latch_sequencer
//
// Purpose:
//   Sequences set/reset commands onto an external NOR SR latch. Each command
//   drives S (set) or R (reset) for PULSE_CYC cycles, lets both drives rest
//   low for SETTLE_CYC cycles, checks the synchronized Q/Qbar feedback for one
//   cycle, reports the outcome, and then idles for GAP_CYC cycles before the
//   next command is accepted.
//
// Parameters:
//   PULSE_CYC   cycles the selected drive is held high        (1..255)
//   SETTLE_CYC  cycles both drives are low before the check   (3..255)
//   GAP_CYC     idle cycles after the check                   (1..255)
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous, active-high reset
//   cmd_valid  in   a command is presented
//   cmd_op     in   1 = set (drive S), 0 = reset (drive R)
//   cmd_ready  out  command accepted on this cycle's edge if cmd_valid is high
//   s_out      out  registered S drive to the latch
//   r_out      out  registered R drive to the latch
//   q_in       in   latch Q feedback (asynchronous to clk)
//   qbar_in    in   latch Qbar feedback (asynchronous to clk)
//   done       out  one-cycle pulse when a command check completes
//   err        out  one-cycle pulse with done when the check failed
//   q_state    out  latch value from the last passing check
// -----------------------------------------------------------------------------
module sr_latch_sequencer #(
   parameter int unsigned PULSE_CYC  = 2,
   parameter int unsigned SETTLE_CYC = 3,
   parameter int unsigned GAP_CYC    = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic cmd_valid,
   input  logic cmd_op,
   output logic cmd_ready,
   output logic s_out,
   output logic r_out,
   input  logic q_in,
   input  logic qbar_in,
   output logic done,
   output logic err,
   output logic q_state
);

   // Counters count down to zero, so each phase loads its length minus one.
   localparam logic [7:0] PULSE_LD  = 8'(PULSE_CYC - 1);
   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] GAP_LD    = 8'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PULSE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_GAP    = 3'd4
   } state_t;

   state_t     state_q;
   logic [7:0] cnt_q;
   logic       op_q;
   logic       s_q;
   logic       r_q;
   logic       done_q;
   logic       err_q;
   logic       q_state_q;
   logic [1:0] q_sync_q;
   logic [1:0] qbar_sync_q;
   logic       check_pass;

   // Two-flop synchronizers for the asynchronous latch feedback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_sync_q    <= 2'b00;
         qbar_sync_q <= 2'b00;
      end else begin
         q_sync_q    <= {q_sync_q[0], q_in};
         qbar_sync_q <= {qbar_sync_q[0], qbar_in};
      end
   end

   // Q must equal op and Qbar its complement; Q == Qbar can never satisfy
   // both terms, so an invalid latch state always fails.
   assign check_pass = (q_sync_q[1] == op_q) && (qbar_sync_q[1] == ~op_q);

   // Sequencing FSM with registered drives and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         op_q      <= 1'b0;
         s_q       <= 1'b0;
         r_q       <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         q_state_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  // Drives are complementary by construction: never both high.
                  s_q     <= cmd_op;
                  r_q     <= ~cmd_op;
                  cnt_q   <= PULSE_LD;
                  state_q <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (cnt_q == 8'd0) begin
                  s_q     <= 1'b0;
                  r_q     <= 1'b0;
                  cnt_q   <= SETTLE_LD;
                  state_q <= ST_SETTLE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == 8'd0) begin
                  state_q <= ST_CHECK;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_CHECK: begin
               done_q <= 1'b1;
               err_q  <= ~check_pass;
               if (check_pass) begin
                  q_state_q <= op_q;
               end
               cnt_q   <= GAP_LD;
               state_q <= ST_GAP;
            end
            ST_GAP: begin
               if (cnt_q == 8'd0) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            default: begin
               // Unreachable encodings recover to a safe idle with drives off.
               s_q     <= 1'b0;
               r_q     <= 1'b0;
               cnt_q   <= 8'd0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign s_out     = s_q;
   assign r_out     = r_q;
   assign done      = done_q;
   assign err       = err_q;
   assign q_state   = q_state_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_sequencer
//
// Self-checking bench for sr_latch_sequencer. A behavioural NOR latch model
// (with injectable faults) closes the feedback loop. Expected timing comes
// from the command-timeline rules: the drive occupies the first PULSE_CYC
// cycles after acceptance, done appears PULSE_CYC+SETTLE_CYC+1 cycles after
// acceptance, and the next command can be taken PULSE_CYC+SETTLE_CYC+GAP_CYC+2
// cycles after acceptance.
// -----------------------------------------------------------------------------
module tb_sr_latch_sequencer;

   localparam int P      = 2;
   localparam int S      = 3;
   localparam int G      = 1;
   localparam int PER    = P + S + G + 2;
   localparam int DONE_K = P + S + 1;

   localparam int P2      = 1;
   localparam int S2      = 3;
   localparam int G2      = 4;
   localparam int PER2    = 10;
   localparam int DONE_K2 = P2 + S2 + 1;

   localparam int M_NORM  = 0;
   localparam int M_ST0   = 1;
   localparam int M_ST1   = 2;
   localparam int M_INV00 = 3;
   localparam int M_INV11 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic cmd_valid = 1'b0;
   logic cmd_op    = 1'b0;
   logic cmd_ready, s_out, r_out, q_in, qbar_in, done, err, q_state;

   logic cmd_valid2 = 1'b0;
   logic cmd_op2    = 1'b0;
   logic cmd_ready2, s_out2, r_out2, q_in2, qbar_in2, done2, err2, q_state2;

   int checks   = 0;
   int failures = 0;
   int mode     = M_NORM;
   logic lq  = 1'b0;
   logic lq2 = 1'b0;

   sr_latch_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_ready(cmd_ready), .s_out(s_out), .r_out(r_out),
      .q_in(q_in), .qbar_in(qbar_in), .done(done), .err(err), .q_state(q_state)
   );

   sr_latch_sequencer #(.PULSE_CYC(P2), .SETTLE_CYC(S2), .GAP_CYC(G2)) dut2 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_op(cmd_op2),
      .cmd_ready(cmd_ready2), .s_out(s_out2), .r_out(r_out2),
      .q_in(q_in2), .qbar_in(qbar_in2), .done(done2), .err(err2), .q_state(q_state2)
   );

   // NOR SR latch behaviour: S forces Q=1, R forces Q=0, otherwise hold.
   always @(s_out, r_out) begin
      if (s_out)      lq = 1'b1;
      else if (r_out) lq = 1'b0;
   end
   always @(s_out2, r_out2) begin
      if (s_out2)      lq2 = 1'b1;
      else if (r_out2) lq2 = 1'b0;
   end
   assign q_in2    = lq2;
   assign qbar_in2 = ~lq2;

   // Fault injection on the main latch feedback.
   always_comb begin
      q_in    = lq;
      qbar_in = ~lq;
      case (mode)
         M_ST0:   begin q_in = 1'b0; qbar_in = 1'b1; end
         M_ST1:   begin q_in = 1'b1; qbar_in = 1'b0; end
         M_INV00: begin q_in = 1'b0; qbar_in = 1'b0; end
         M_INV11: begin q_in = 1'b1; qbar_in = 1'b1; end
         default: ;
      endcase
   end

   // Outcome of a check given the commanded op and the latch behaviour.
   function automatic bit pass_of(input bit op, input int md);
      case (md)
         M_NORM:  return 1'b1;
         M_ST0:   return !op;
         M_ST1:   return op;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Issue one command to the default-parameter DUT and check its full timeline.
   // Called at a negedge while the DUT is idle; returns at the negedge of the
   // last busy cycle's successor, where cmd_ready is high again.
   task automatic run_cmd(input bit op, input int md, input bit exp_err,
                          input bit exp_q, input string tag);
      $display("cmd %s op=%0d mode=%0d exp_err=%0d exp_q=%0d", tag, op, md, exp_err, exp_q);
      chk({tag, " ready_before"}, cmd_ready, 1);
      mode      = md;
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 1'($urandom);
      for (int k = 0; k < PER; k++) begin
         @(negedge clk);
         chk({tag, " s_out"}, s_out, (k < P) && op);
         chk({tag, " r_out"}, r_out, (k < P) && !op);
         chk({tag, " done"}, done, k == DONE_K);
         chk({tag, " err"}, err, (k == DONE_K) && exp_err);
         chk({tag, " cmd_ready"}, cmd_ready, k == PER - 1);
         if (k == DONE_K) chk({tag, " q_state"}, q_state, exp_q);
      end
   endtask

   typedef struct {
      bit    op;
      int    md;
      bit    exp_err;
      bit    exp_q;
      string tag;
   } vec_t;

   vec_t tbl[9];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int  last, n_acc, k, mop, mmode, qs;
      bit  next_op, pend_op, acc_pending, e_done, e_pass;

      tbl[0] = '{1'b1, M_NORM,  1'b0, 1'b1, "set_ok"};
      tbl[1] = '{1'b0, M_NORM,  1'b0, 1'b0, "reset_ok"};
      tbl[2] = '{1'b1, M_ST0,   1'b1, 1'b0, "set_stuck0"};
      tbl[3] = '{1'b1, M_INV00, 1'b1, 1'b0, "set_inv00"};
      tbl[4] = '{1'b1, M_NORM,  1'b0, 1'b1, "set_ok2"};
      tbl[5] = '{1'b1, M_NORM,  1'b0, 1'b1, "set_repeat"};
      tbl[6] = '{1'b0, M_INV11, 1'b1, 1'b1, "reset_inv11"};
      tbl[7] = '{1'b0, M_ST1,   1'b1, 1'b1, "reset_stuck1"};
      tbl[8] = '{1'b0, M_ST0,   1'b0, 1'b0, "reset_stuck0"};

      // Reset state.
      @(negedge clk);
      chk("rst cmd_ready", cmd_ready, 1);
      chk("rst s_out", s_out, 0);
      chk("rst r_out", r_out, 0);
      chk("rst done", done, 0);
      chk("rst err", err, 0);
      chk("rst q_state", q_state, 0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven command sequence.
      for (int i = 0; i < 9; i++) begin
         run_cmd(tbl[i].op, tbl[i].md, tbl[i].exp_err, tbl[i].exp_q, tbl[i].tag);
      end
      mode = M_NORM;

      // Short-pulse / long-gap instance timing.
      $display("cmd dut2 set op=1");
      chk("dut2 ready_before", cmd_ready2, 1);
      cmd_valid2 = 1'b1;
      cmd_op2    = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid2 = 1'b0;
      for (int kk = 0; kk < PER2; kk++) begin
         @(negedge clk);
         chk("dut2 s_out", s_out2, kk < P2);
         chk("dut2 r_out", r_out2, 0);
         chk("dut2 done", done2, kk == DONE_K2);
         chk("dut2 err", err2, 0);
         chk("dut2 cmd_ready", cmd_ready2, kk == PER2 - 1);
      end
      chk("dut2 q_state", q_state2, 1);

      // cmd_valid held high with alternating op: one acceptance per period.
      $display("cmd back_to_back alternating ops");
      last        = -1;
      n_acc       = 0;
      next_op     = 1'b1;
      pend_op     = 1'b0;
      acc_pending = 1'b0;
      cmd_valid   = 1'b1;
      for (int c = 0; c < 64; c++) begin
         if (c > 0) @(negedge clk);
         chk("b2b overlap", s_out & r_out, 0);
         if (acc_pending) begin
            chk("b2b s_drive", s_out, pend_op);
            chk("b2b r_drive", r_out, !pend_op);
            acc_pending = 1'b0;
         end
         if (cmd_ready) begin
            if (last >= 0) chk("b2b period", c - last, PER);
            last        = c;
            n_acc++;
            cmd_op      = next_op;
            pend_op     = next_op;
            acc_pending = 1'b1;
            next_op     = !next_op;
         end
      end
      cmd_valid = 1'b0;
      chk("b2b accept_count", n_acc, 8);
      @(negedge clk);
      chk("b2b final q_state", q_state, 0);

      // Reset asserted during PULSE.
      run_cmd(1'b1, M_NORM, 1'b0, 1'b1, "pre_rst_set");
      $display("cmd rst_in_pulse op=1");
      cmd_valid = 1'b1;
      cmd_op    = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rstp s_out_before", s_out, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("rstp s_out", s_out, 0);
      chk("rstp r_out", r_out, 0);
      chk("rstp done", done, 0);
      chk("rstp err", err, 0);
      chk("rstp q_state", q_state, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) chk("rstp ready_after", cmd_ready, 1);
         chk("rstp no_done", done, 0);
         chk("rstp no_drive", s_out | r_out, 0);
      end

      // Randomized traffic against the timeline model.
      mode  = M_NORM;
      k     = -1;
      mop   = 0;
      mmode = M_NORM;
      qs    = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         e_done = (k == DONE_K);
         e_pass = pass_of(mop[0], mmode);
         if (e_done && e_pass) qs = mop;
         chk("rnd cmd_ready", cmd_ready, k < 0);
         chk("rnd s_out", s_out, (k >= 0) && (k < P) && (mop == 1));
         chk("rnd r_out", r_out, (k >= 0) && (k < P) && (mop == 0));
         chk("rnd done", done, e_done);
         chk("rnd err", err, e_done && !e_pass);
         chk("rnd q_state", q_state, qs);
         chk("rnd overlap", s_out & r_out, 0);
         if (e_done) $display("rnd cyc=%0d op=%0d mode=%0d err=%0d q_state=%0d", cyc, mop, mmode, err, q_state);
         if (k < 0 && $urandom_range(0, 3) == 0) begin
            mode = ($urandom_range(0, 1) == 0) ? M_NORM : int'($urandom_range(1, 4));
         end
         cmd_valid = ($urandom_range(0, 2) == 0);
         cmd_op    = 1'($urandom);
         if (k < 0) begin
            if (cmd_valid) begin
               k     = 0;
               mop   = int'(cmd_op);
               mmode = mode;
            end
         end else begin
            k++;
            if (k == PER - 1) k = -1;
         end
      end
      cmd_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
